// File: rtl/bt_air_channel_n.sv
// rtl/bt_air_channel_n.sv - shared N-node air channel with propagation delay, collisions and bit errors
module bt_air_channel_n #(
    parameter int          NODES     = 4,
    parameter int          DELAY     = 2,
    parameter int          FKW       = 7,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   clk_6M,
    input  logic                   rst,
    input  logic [NODES-1:0]       txbit,
    input  logic [NODES-1:0]       txen,
    input  logic [NODES-1:0]       rxen,
    input  logic [NODES*FKW-1:0]   lc_fk,
    input  logic [NODES-1:0]       loadfreq_p,
    input  logic [7:0]             ber_thresh,
    input  logic [NODES-1:0]       force_err_p,
    input  logic                   cnt_clr_p,
    output logic [NODES-1:0]       rxbit,
    output logic [NODES-1:0]       rx_valid,
    output logic [NODES-1:0]       collision,
    output logic [NODES*FKW-1:0]   tuned_fk,
    output logic [15:0]            coll_cnt,
    output logic [15:0]            err_cnt
);

    logic [NODES*FKW-1:0] fk_q;
    logic [NODES-1:0]     d_en, d_bit;
    logic [NODES*FKW-1:0] d_fk;
    logic [15:0]          lfsr;
    logic [NODES-1:0]     pend_q, pend_d;
    logic [NODES-1:0]     rx_d, valid_d, coll_d;
    logic [3:0]           hits, n_coll, n_err;
    logic                 hbit, err, ber_hit, pend_now;
    logic [16:0]          coll_sum, err_sum;

    assign tuned_fk = fk_q;

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            fk_q <= '0;
        end else begin
            for (int i = 0; i < NODES; i++)
                if (loadfreq_p[i]) fk_q[i*FKW +: FKW] <= lc_fk[i*FKW +: FKW];
        end
    end

    // The transmitter's frequency travels with its bit so a mid-flight retune on either side is honoured.
    generate
        if (DELAY == 0) begin : g_nodelay
            assign d_en  = txen;
            assign d_bit = txbit;
            assign d_fk  = fk_q;
        end else begin : g_delay
            logic [NODES-1:0]     en_sr  [DELAY];
            logic [NODES-1:0]     bit_sr [DELAY];
            logic [NODES*FKW-1:0] fk_sr  [DELAY];

            always_ff @(posedge clk_6M) begin
                if (rst) begin
                    for (int s = 0; s < DELAY; s++) begin
                        en_sr[s]  <= '0;
                        bit_sr[s] <= '0;
                        fk_sr[s]  <= '0;
                    end
                end else begin
                    en_sr[0]  <= txen;
                    bit_sr[0] <= txbit;
                    fk_sr[0]  <= fk_q;
                    for (int s = 1; s < DELAY; s++) begin
                        en_sr[s]  <= en_sr[s-1];
                        bit_sr[s] <= bit_sr[s-1];
                        fk_sr[s]  <= fk_sr[s-1];
                    end
                end
            end

            assign d_en  = en_sr[DELAY-1];
            assign d_bit = bit_sr[DELAY-1];
            assign d_fk  = fk_sr[DELAY-1];
        end
    endgenerate

    always_comb begin
        rx_d     = '0;
        valid_d  = '0;
        coll_d   = '0;
        pend_d   = pend_q;
        n_coll   = '0;
        n_err    = '0;
        hits     = '0;
        hbit     = 1'b0;
        err      = 1'b0;
        pend_now = 1'b0;
        ber_hit  = (lfsr[15:8] < ber_thresh);
        for (int j = 0; j < NODES; j++) begin
            hits = '0;
            hbit = 1'b0;
            for (int i = 0; i < NODES; i++) begin
                if (i != j && d_en[i] && d_fk[i*FKW +: FKW] == fk_q[j*FKW +: FKW]) begin
                    hits = hits + 4'd1;
                    hbit = d_bit[i];
                end
            end
            pend_now  = pend_q[j] | force_err_p[j];
            pend_d[j] = pend_now;
            err       = 1'b0;
            if (!txen[j] && rxen[j]) begin
                if (hits == 4'd0) begin
                    rx_d[j] = lfsr[0];
                end else if (hits == 4'd1) begin
                    err        = pend_now | ber_hit;
                    rx_d[j]    = hbit ^ err;
                    valid_d[j] = 1'b1;
                    pend_d[j]  = 1'b0;
                    if (err) n_err = n_err + 4'd1;
                end else begin
                    rx_d[j]   = lfsr[0];
                    coll_d[j] = 1'b1;
                    n_coll    = n_coll + 4'd1;
                end
            end
        end
        coll_sum = {1'b0, coll_cnt} + {13'd0, n_coll};
        err_sum  = {1'b0, err_cnt} + {13'd0, n_err};
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            rxbit     <= '0;
            rx_valid  <= '0;
            collision <= '0;
            pend_q    <= '0;
            lfsr      <= LFSR_SEED;
            coll_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            rxbit     <= rx_d;
            rx_valid  <= valid_d;
            collision <= coll_d;
            pend_q    <= pend_d;
            lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            if (cnt_clr_p) begin
                coll_cnt <= '0;
                err_cnt  <= '0;
            end else begin
                coll_cnt <= coll_sum[16] ? 16'hFFFF : coll_sum[15:0];
                err_cnt  <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_bt_air_channel_n.sv
// tb/tb_bt_air_channel_n.sv - directed self-checking bench for bt_air_channel_n
module tb_bt_air_channel_n;
    localparam int          N    = 3;
    localparam int          D    = 2;
    localparam int          FKW  = 7;
    localparam logic [15:0] SEED = 16'hACE1;

    logic             clk_6M = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     txbit = '0, txen = '0, rxen = '0, loadfreq_p = '0, force_err_p = '0;
    logic [N*FKW-1:0] lc_fk = '0;
    logic [7:0]       ber_thresh = '0;
    logic             cnt_clr_p = 1'b0;
    logic [N-1:0]     rxbit, rx_valid, collision;
    logic [N*FKW-1:0] tuned_fk;
    logic [15:0]      coll_cnt, err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr;
    logic        noise_exp, ber_exp;

    bt_air_channel_n #(.NODES(N), .DELAY(D), .FKW(FKW), .LFSR_SEED(SEED)) dut (
        .clk_6M(clk_6M), .rst(rst), .txbit(txbit), .txen(txen), .rxen(rxen),
        .lc_fk(lc_fk), .loadfreq_p(loadfreq_p), .ber_thresh(ber_thresh),
        .force_err_p(force_err_p), .cnt_clr_p(cnt_clr_p), .rxbit(rxbit),
        .rx_valid(rx_valid), .collision(collision), .tuned_fk(tuned_fk),
        .coll_cnt(coll_cnt), .err_cnt(err_cnt)
    );

    always #5 clk_6M = ~clk_6M;

    // Reference noise source: value the DUT sampled at each edge.
    always @(posedge clk_6M) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        noise_exp <= m_lfsr[0];
        ber_exp   <= (m_lfsr[15:8] < ber_thresh);
    end

    task automatic step();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic tune(input int node, input logic [FKW-1:0] fk);
        lc_fk[node*FKW +: FKW] = fk;
        loadfreq_p = '0;
        loadfreq_p[node] = 1'b1;
        step();
        loadfreq_p = '0;
        n_cmp++;
        if (tuned_fk[node*FKW +: FKW] !== fk) begin
            n_bad++;
            $display("FAIL tune node%0d got %0d exp %0d", node, tuned_fk[node*FKW +: FKW], fk);
        end
    endtask

    task automatic clear_counters();
        cnt_clr_p = 1'b1;
        step();
        cnt_clr_p = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_cmp++;
        if ({rxbit, rx_valid, collision, tuned_fk, coll_cnt, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_state got rx=%b v=%b c=%b fk=%h cc=%0d ec=%0d exp all 0",
                     rxbit, rx_valid, collision, tuned_fk, coll_cnt, err_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_delivery();
        logic [7:0] pat;
        logic       e;
        pat = 8'hA5;
        tune(0, 7'd10);
        tune(1, 7'd10);
        rxen = 3'b010;
        clear_counters();
        for (int k = 0; k < 50; k++) begin
            txen[0]  = (k < 48);
            txbit[0] = (k < 48) ? pat[k/6] : 1'b0;
            step();
            if (k >= 2) begin
                e = pat[(k-2)/6];
                n_cmp++;
                if (rxbit[1] !== e || rx_valid[1] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL delivery k=%0d got bit=%b v=%b exp bit=%b v=1", k, rxbit[1], rx_valid[1], e);
                end
            end
        end
        txen = '0;
        n_cmp++;
        if (err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL delivery_err_cnt got %0d exp 0", err_cnt);
        end
    endtask

    task automatic test_noise();
        tune(1, 7'd11);
        rxen = 3'b010;
        for (int k = 0; k < 10; k++) begin
            txen[0]  = 1'b1;
            txbit[0] = k[0];
            step();
            if (k >= 2) begin
                n_cmp++;
                if (rxbit[1] !== noise_exp || rx_valid[1] !== 1'b0 || collision[1] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL noise k=%0d got bit=%b v=%b c=%b exp bit=%b v=0 c=0",
                             k, rxbit[1], rx_valid[1], collision[1], noise_exp);
                end
            end
        end
        txen = '0;
    endtask

    task automatic test_collision();
        logic e;
        tune(0, 7'd20);
        tune(1, 7'd20);
        tune(2, 7'd20);
        rxen = 3'b100;
        clear_counters();
        for (int k = 0; k < 14; k++) begin
            txen[1:0]  = (k < 10) ? 2'b11 : 2'b00;
            txbit[1:0] = k[1:0];
            step();
            e = (k >= 2 && k < 12);
            n_cmp++;
            if (collision[2] !== e || rx_valid[2] !== 1'b0) begin
                n_bad++;
                $display("FAIL collision k=%0d got c=%b v=%b exp c=%b v=0", k, collision[2], rx_valid[2], e);
            end
        end
        txen = '0;
        n_cmp++;
        if (coll_cnt !== 16'd10) begin
            n_bad++;
            $display("FAIL coll_cnt got %0d exp 10", coll_cnt);
        end
    endtask

    task automatic test_force_err();
        logic [7:0] pat;
        logic       e;
        pat = 8'hCA;
        tune(0, 7'd10);
        tune(1, 7'd10);
        rxen = 3'b010;
        ber_thresh = 8'd0;
        clear_counters();
        for (int k = 0; k < 10; k++) begin
            txen[0]  = (k < 8);
            txbit[0] = (k < 8) ? pat[k] : 1'b0;
            force_err_p[1] = (k == 4);
            step();
            force_err_p = '0;
            if (k >= 2) begin
                e = pat[k-2] ^ (k == 4);
                n_cmp++;
                if (rxbit[1] !== e || rx_valid[1] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL force_err k=%0d got bit=%b v=%b exp bit=%b v=1", k, rxbit[1], rx_valid[1], e);
                end
            end
        end
        txen = '0;
        n_cmp++;
        if (err_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL force_err_cnt got %0d exp 1", err_cnt);
        end
        clear_counters();
        n_cmp++;
        if (err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL err_cnt_clear got %0d exp 0", err_cnt);
        end
        // A pulse with nothing in flight must wait for the next delivered bit.
        force_err_p[1] = 1'b1;
        step();
        force_err_p = '0;
        step();
        for (int k = 0; k < 6; k++) begin
            txen[0]  = (k < 4);
            txbit[0] = 1'b1;
            step();
            if (k >= 2) begin
                e = (k != 2);
                n_cmp++;
                if (rxbit[1] !== e || rx_valid[1] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL force_pend k=%0d got bit=%b v=%b exp bit=%b v=1", k, rxbit[1], rx_valid[1], e);
                end
            end
        end
        txen = '0;
        n_cmp++;
        if (err_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL force_pend_cnt got %0d exp 1", err_cnt);
        end
    endtask

    task automatic test_deaf();
        rxen  = 3'b001;
        txen  = 3'b011;
        txbit = 3'b011;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (rxbit[0] !== 1'b0 || rx_valid[0] !== 1'b0 || collision[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL deaf k=%0d got bit=%b v=%b c=%b exp 0 0 0", k, rxbit[0], rx_valid[0], collision[0]);
            end
        end
        txen = 3'b010;
        step();
        n_cmp++;
        if (rxbit[0] !== 1'b1 || rx_valid[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL undeaf got bit=%b v=%b exp bit=1 v=1", rxbit[0], rx_valid[0]);
        end
        txen  = '0;
        txbit = '0;
    endtask

    task automatic test_reset_mid();
        rxen     = 3'b010;
        txen[0]  = 1'b1;
        txbit[0] = 1'b1;
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        step();
        n_cmp++;
        if ({rxbit, rx_valid, collision, tuned_fk, coll_cnt, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid got rx=%b v=%b c=%b fk=%h cc=%0d ec=%0d exp all 0",
                     rxbit, rx_valid, collision, tuned_fk, coll_cnt, err_cnt);
        end
        rst = 1'b0;
        for (int k = 0; k < D; k++) begin
            step();
            n_cmp++;
            if (rx_valid[1] !== 1'b0 || rxbit[1] !== noise_exp) begin
                n_bad++;
                $display("FAIL stale k=%0d got bit=%b v=%b exp bit=%b v=0", k, rxbit[1], rx_valid[1], noise_exp);
            end
        end
        step();
        n_cmp++;
        if (rx_valid[1] !== 1'b1 || rxbit[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL first_post_reset got bit=%b v=%b exp bit=1 v=1", rxbit[1], rx_valid[1]);
        end
    endtask

    task automatic test_ber();
        int exp_errs;
        exp_errs   = 0;
        ber_thresh = 8'h80;
        clear_counters();
        for (int k = 0; k < 12; k++) begin
            step();
            exp_errs += int'(ber_exp);
            n_cmp++;
            if (rxbit[1] !== (1'b1 ^ ber_exp) || rx_valid[1] !== 1'b1) begin
                n_bad++;
                $display("FAIL ber k=%0d got bit=%b v=%b exp bit=%b v=1", k, rxbit[1], rx_valid[1], 1'b1 ^ ber_exp);
            end
        end
        n_cmp++;
        if (err_cnt !== 16'(exp_errs)) begin
            n_bad++;
            $display("FAIL ber_err_cnt got %0d exp %0d", err_cnt, exp_errs);
        end
        ber_thresh = '0;
        txen = '0;
    endtask

    initial begin
        test_reset();
        test_delivery();
        test_noise();
        test_collision();
        test_force_err();
        test_deaf();
        test_reset_mid();
        test_ber();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bt_air_channel_n.md
# bt_air_channel_n

Synthesizable N-node air-channel model for multi-device Bluetooth baseband simulation. It replaces the point-to-point two-radio pairing with a shared medium. Each node's radio side (txbit/txen/rxen/nxtfk/loadfreq_p) connects to one port slice. Any node can hear any other node tuned to the same hop frequency, with configurable propagation delay, collision detection, bit-error injection and statistics. It sits between the bt_top instances in piconet and scatternet benches, and runs on the common 6 MHz bit clock.

## Interface
- NODES, 4: number of attached devices (2..8).
- DELAY, 2: propagation delay in clk_6M cycles (0..15), excluding the output register.
- FKW, 7: hop-frequency index width.
- LFSR_SEED, 16'hACE1: noise/error LFSR reset value (nonzero).

- clk_6M  in  1  6 MHz clock.
- rst  in  1  synchronous reset, active-high.
- txbit  in  NODES  transmit bit per node.
- txen  in  NODES  transmitter enable per node (txbit_period).
- rxen  in  NODES  receiver enable per node (rxbit_period).
- lc_fk  in  NODES*FKW  next hop frequency per node; slice i is [i*FKW +: FKW].
- loadfreq_p  in  NODES  one-cycle pulse that loads lc_fk slice into the node's tuned register.
- ber_thresh  in  8  error probability per cycle, thresh/256; 0 disables random errors.
- force_err_p  in  NODES  one-cycle pulse that inverts the next delivered bit to that node.
- cnt_clr_p  in  1  clears all counters.
- rxbit  out  NODES  received bit per node.
- rx_valid  out  NODES  exactly one in-band transmitter was heard.
- collision  out  NODES  two or more in-band transmitters were heard.
- tuned_fk  out  NODES*FKW  current tuned frequency per node.
- coll_cnt  out  16  saturating count of receiver-cycles with collision.
- err_cnt  out  16  saturating count of bits delivered inverted.

## Operation
- Tuning: on loadfreq_p[i], tuned_fk[i] <= lc_fk[i]. Without the pulse, the value holds.
- Delay line: per node, a DELAY-stage shift register of {txen, txbit, tuned_fk}. The tail is d_en/d_bit/d_fk. With DELAY=0, the tail equals the current inputs.
- Match for receiver j: m[i][j] = d_en[i] & (d_fk[i]==tuned_fk[j]) & (i!=j). hits = popcount over i.
- Half-duplex: if txen[j] is high (undelayed), receiver j is deaf. Its next outputs are rxbit=0, rx_valid=0, collision=0.
- Receiver j with rxen[j]=0 and not deaf: rxbit=0, rx_valid=0, collision=0.
- Receiver j with rxen[j]=1 and not deaf:
  - hits=0: rxbit=lfsr[0] (noise), rx_valid=0, collision=0.
  - hits=1: rxbit = d_bit of the hit node XOR err[j], rx_valid=1, collision=0.
  - hits>=2: rxbit=lfsr[0], rx_valid=0, collision=1.
- err[j] = force_pend[j] | (lfsr[15:8] < ber_thresh).
  - force_pend[j] sets on force_err_p[j].
  - force_pend[j] clears on the first cycle receiver j delivers with hits=1. That cycle uses err=1.
  - force_err_p arriving on the same cycle as a delivery applies to that delivery.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle.
- Counters, both saturating at 16'hFFFF:
  - coll_cnt += number of receivers with collision this cycle.
  - err_cnt += number of receivers delivering with err=1.
  - cnt_clr_p has priority over increment in the same cycle.

## Timing
- Reset (rst=1 at a clk_6M edge): all outputs 0, tuned_fk 0, delay lines 0, force_pend 0, counters 0, LFSR=LFSR_SEED. Reset asserted mid-packet discards all in-flight bits. The first post-reset rxbit is driven by a txbit sampled after reset release.
- Latency: txbit at cycle t appears on rxbit at t+DELAY+1.
- Frequency comparison uses the transmitter's tuned_fk as delayed with its bit, against the receiver's tuned_fk at delivery time. A receiver retuning mid-flight therefore loses bits that do not match.
- loadfreq_p at cycle t: the new tuned_fk is visible at t+1 and enters the delay line at t+1.
- rxbit, rx_valid and collision are registered with no combinational input-to-output path.
- Simultaneous loadfreq_p on a node that is transmitting: in-flight bits keep their old frequency.

## Test plan
- NODES=2, DELAY=2, both tuned to 7'd10. Node0 transmits 0xA5 (LSB first, 6 cycles per bit) and node1 has rxen=1 -> node1 rxbit reproduces the pattern 3 cycles later, rx_valid=1 throughout, err_cnt=0.
- Same setup, node1 tuned to 7'd11 -> rx_valid=0, collision=0, and rxbit follows lfsr[0] starting from the seed 16'hACE1 sequence.
- NODES=3, nodes 0 and 1 transmit on 7'd20 while node2 listens on 7'd20 for 10 cycles -> collision[2]=1 for 10 cycles, coll_cnt=10.
- force_err_p[1] pulsed mid-packet with ber_thresh=0 -> exactly one bit inverted at node1, err_cnt=1. A subsequent cnt_clr_p clears it to 0.
- Node0 txen and rxen both high while node1 transmits on the same frequency -> node0 rxbit=0 and rx_valid=0 (deaf).
- rst asserted for 1 cycle during a transmission -> all outputs 0 the next cycle. No stale bit appears within DELAY+1 cycles after release. coll_cnt and err_cnt are 0.
